net_weight_loader: RTL and testbench

Parametrised weight-load sequencer for the Q-network datapath. It walks all three weight layers (hidden 1, hidden 2, output) out of a synchronous weight memory and streams each word with layer code and in-layer address onto the `main_net` weight-load port. It adds ready/valid backpressure, an abort path and a done flag, so weight initialisation and target-net refresh are sequenced in hardware rather than by the bench.

---
 rtl/net_weight_loader.sv | 176 +++++++++++++++++
 tb/tb_net_weight_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_weight_loader.sv
// Weight-load sequencer: walks the three Q-network weight layers out of a synchronous
// memory and streams {layer, addr, word} through a 2-entry FIFO with ready/valid backpressure.
//
// state   | meaning
// S_IDLE  | waiting for i_start, nothing in flight
// S_LOAD  | issuing reads for layers 01, 10, 11
// S_DRAIN | all reads issued, emptying FIFO and in-flight read
// S_DONE  | every word transferred, done flag held
module net_weight_loader #(
   parameter int DATA_WIDTH                    = 32,
   parameter int LAYER_WIDTH                   = 2,
   parameter int NUMBER_OF_INPUT_NODE          = 2,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 24,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 24,
   parameter int NUMBER_OF_OUTPUT_NODE         = 3,
   parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_start,
   input  logic                            i_abort,
   input  logic                            i_ready,
   output logic                            o_mem_rd_en,
   output logic [LAYER_WIDTH-1:0]          o_mem_rd_layer,
   output logic [WEIGHT_COUNTER_WIDTH-1:0] o_mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]           i_mem_rd_data,
   output logic                            o_weight_valid,
   output logic [LAYER_WIDTH-1:0]          o_weight_layer,
   output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
   output logic [DATA_WIDTH-1:0]           o_weight,
   output logic                            o_load_weight_done,
   output logic                            o_busy
);

   localparam int L1_WORDS = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
   localparam int L2_WORDS = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
   localparam int L3_WORDS = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

   localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L1_LAST = WEIGHT_COUNTER_WIDTH'(L1_WORDS - 1);
   localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L2_LAST = WEIGHT_COUNTER_WIDTH'(L2_WORDS - 1);
   localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L3_LAST = WEIGHT_COUNTER_WIDTH'(L3_WORDS - 1);

   localparam logic [LAYER_WIDTH-1:0] LAYER_H1  = LAYER_WIDTH'(1);
   localparam logic [LAYER_WIDTH-1:0] LAYER_H2  = LAYER_WIDTH'(2);
   localparam logic [LAYER_WIDTH-1:0] LAYER_OUT = LAYER_WIDTH'(3);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;

   logic [LAYER_WIDTH-1:0]          r_rd_layer;
   logic [WEIGHT_COUNTER_WIDTH-1:0] r_rd_addr;
   logic [WEIGHT_COUNTER_WIDTH-1:0] w_last_addr;

   logic                            r_inflight;
   logic [LAYER_WIDTH-1:0]          r_inflight_layer;
   logic [WEIGHT_COUNTER_WIDTH-1:0] r_inflight_addr;

   logic [DATA_WIDTH-1:0]           r_fifo_data  [2];
   logic [LAYER_WIDTH-1:0]          r_fifo_layer [2];
   logic [WEIGHT_COUNTER_WIDTH-1:0] r_fifo_addr  [2];
   logic                            r_wr_ptr;
   logic                            r_rd_ptr;
   logic [1:0]                      r_count;

   logic                            w_valid;
   logic                            w_pop;
   logic [2:0]                      w_level;
   logic                            w_issue;
   logic                            w_final_read;

   assign w_valid = (r_count != 2'd0);
   assign w_pop   = w_valid && i_ready;

   // Words held or on their way after this cycle; a new read only fits below two.
   assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = (r_state == S_LOAD) && !i_abort && (w_level < 3'd2);

   always_comb begin
      w_last_addr = L3_LAST;
      case (r_rd_layer)
         LAYER_H1: w_last_addr = L1_LAST;
         LAYER_H2: w_last_addr = L2_LAST;
         default:  w_last_addr = L3_LAST;
      endcase
   end

   assign w_final_read = w_issue && (r_rd_layer == LAYER_OUT) && (r_rd_addr == w_last_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_final_read) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_level == 3'd0) w_state_nxt = S_DONE;
            S_DONE:  if (i_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Read cursor wraps back to layer 01 / address 0 after the final read, ready for a reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_layer <= LAYER_H1;
         r_rd_addr  <= '0;
      end else if (i_abort) begin
         r_rd_layer <= LAYER_H1;
         r_rd_addr  <= '0;
      end else if (w_issue) begin
         if (r_rd_addr == w_last_addr) begin
            r_rd_addr  <= '0;
            r_rd_layer <= (r_rd_layer == LAYER_OUT) ? LAYER_H1 : r_rd_layer + LAYER_WIDTH'(1);
         end else begin
            r_rd_addr <= r_rd_addr + WEIGHT_COUNTER_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight       <= 1'b0;
         r_inflight_layer <= '0;
         r_inflight_addr  <= '0;
         r_wr_ptr         <= 1'b0;
         r_rd_ptr         <= 1'b0;
         r_count          <= 2'd0;
      end else if (i_abort) begin
         r_inflight <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_inflight       <= w_issue;
         r_inflight_layer <= r_rd_layer;
         r_inflight_addr  <= r_rd_addr;
         if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   // Storage needs no reset: entries are only visible through r_count.
   always_ff @(posedge clk) begin
      if (r_inflight) begin
         r_fifo_data[r_wr_ptr]  <= i_mem_rd_data;
         r_fifo_layer[r_wr_ptr] <= r_inflight_layer;
         r_fifo_addr[r_wr_ptr]  <= r_inflight_addr;
      end
   end

   assign o_mem_rd_en        = w_issue;
   assign o_mem_rd_layer     = w_issue ? r_rd_layer : '0;
   assign o_mem_rd_addr      = w_issue ? r_rd_addr : '0;
   assign o_weight_valid     = w_valid;
   assign o_weight           = w_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign o_weight_layer     = w_valid ? r_fifo_layer[r_rd_ptr] : '0;
   assign o_weight_addr      = w_valid ? r_fifo_addr[r_rd_ptr] : '0;
   assign o_load_weight_done = (r_state == S_DONE);
   assign o_busy             = (r_state == S_LOAD) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_net_weight_loader.sv
// Directed bench for net_weight_loader: memory model, word scoreboard, stall/abort/reset cases.
module tb_net_weight_loader;

   localparam int TOTAL = 747;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_abort;
   logic        i_ready;
   logic        o_mem_rd_en;
   logic [1:0]  o_mem_rd_layer;
   logic [10:0] o_mem_rd_addr;
   logic [31:0] i_mem_rd_data;
   logic        o_weight_valid;
   logic [1:0]  o_weight_layer;
   logic [10:0] o_weight_addr;
   logic [31:0] o_weight;
   logic        o_load_weight_done;
   logic        o_busy;

   net_weight_loader dut (
      .clk                (clk),
      .rst                (rst),
      .i_start            (i_start),
      .i_abort            (i_abort),
      .i_ready            (i_ready),
      .o_mem_rd_en        (o_mem_rd_en),
      .o_mem_rd_layer     (o_mem_rd_layer),
      .o_mem_rd_addr      (o_mem_rd_addr),
      .i_mem_rd_data      (i_mem_rd_data),
      .o_weight_valid     (o_weight_valid),
      .o_weight_layer     (o_weight_layer),
      .o_weight_addr      (o_weight_addr),
      .o_weight           (o_weight),
      .o_load_weight_done (o_load_weight_done),
      .o_busy             (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [1:0] l, input logic [10:0] a);
      return {4'hC, 2'b00, l, 5'h00, a, ~a[7:0]};
   endfunction

   function automatic logic [12:0] idx2tag(input int idx);
      if (idx < 72)         return {2'd1, 11'(idx)};
      else if (idx < 672)   return {2'd2, 11'(idx - 72)};
      else if (idx < TOTAL) return {2'd3, 11'(idx - 672)};
      else                  return 13'h0;
   endfunction

   // Synchronous weight memory: data valid exactly one cycle after the strobe, junk otherwise.
   always @(posedge clk) begin
      if (o_mem_rd_en) i_mem_rd_data <= mem_word(o_mem_rd_layer, o_mem_rd_addr);
      else             i_mem_rd_data <= 32'hDEAD_BEEF;
   end

   bit rdy_rand = 1'b0;
   always @(posedge clk) begin
      if (rdy_rand) begin
         #1;
         i_ready = 1'($urandom_range(0, 1));
      end
   end

   bit          mon_on = 1'b0;
   int          n_words, n_issued, n_xfer;
   bit          prev_stall;
   logic [31:0] prev_w;
   logic [12:0] prev_tag;
   logic [12:0] exp_tag;

   task automatic sb_reset();
      n_words    = 0;
      n_issued   = 0;
      n_xfer     = 0;
      prev_stall = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_on && !rst) begin
         if (prev_stall) begin
            check("stall_valid", {31'h0, o_weight_valid}, 32'h1);
            check("stall_word", o_weight, prev_w);
            check("stall_tag", {19'h0, o_weight_layer, o_weight_addr}, {19'h0, prev_tag});
         end
         if (!o_weight_valid)
            check("idle_tag_zero", {19'h0, o_weight_layer, o_weight_addr}, 32'h0);
         if (o_mem_rd_en) n_issued++;
         if (o_weight_valid && i_ready) begin
            exp_tag = idx2tag(n_words);
            check("word_tag", {19'h0, o_weight_layer, o_weight_addr}, {19'h0, exp_tag});
            check("word_data", o_weight, mem_word(exp_tag[12:11], exp_tag[10:0]));
            n_words++;
            n_xfer++;
         end
         check("outstanding_le2", {31'h0, (n_issued - n_xfer) <= 2}, 32'h1);
         prev_stall = o_weight_valid && !i_ready;
         prev_w     = o_weight;
         prev_tag   = {o_weight_layer, o_weight_addr};
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!o_load_weight_done && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_timeout", {31'h0, o_load_weight_done}, 32'h1);
   endtask

   task automatic wait_tag(input logic [12:0] tag, input int budget);
      int c = 0;
      while (!(o_weight_valid && {o_weight_layer, o_weight_addr} == tag) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("tag_reached", {31'h0, o_weight_valid}, 32'h1);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {o_mem_rd_en, o_weight_valid, o_load_weight_done, o_busy,
                  o_mem_rd_layer, o_mem_rd_addr, o_weight_layer, o_weight_addr}, 32'h0);
      check({tag, "_word"}, o_weight, 32'h0);
   endtask

   initial begin
      int rd_w;
      int hs;
      rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b1;
      #1 check_all_zero("reset_outputs");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Full load, ready held high: exact cycle timing.
      sb_reset(); mon_on = 1'b1;
      pulse_start();
      for (int c = 1; c <= 750; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("c1_busy", {31'h0, o_busy}, 32'h1);
            check("c1_rd_en", {31'h0, o_mem_rd_en}, 32'h1);
            check("c1_valid", {31'h0, o_weight_valid}, 32'h0);
         end
         if (c == 2) check("c2_valid", {31'h0, o_weight_valid}, 32'h0);
         if (c == 3) check("c3_valid", {31'h0, o_weight_valid}, 32'h1);
         if (c == 749) check("c749_busy_done", {30'h0, o_busy, o_load_weight_done}, 32'h2);
         if (c == 750) check("c750_busy_done", {30'h0, o_busy, o_load_weight_done}, 32'h1);
      end
      check("full_words", n_words, TOTAL);

      // Random backpressure.
      sb_reset();
      rdy_rand = 1'b1;
      pulse_start();
      wait_done(4000);
      rdy_rand = 1'b0;
      i_ready  = 1'b1;
      check("random_words", n_words, TOTAL);

      // Ten stalled cycles after the first valid word, then gap-free streaming.
      sb_reset();
      i_ready = 1'b0;
      pulse_start();
      wait_tag({2'd1, 11'd0}, 10);
      rd_w = o_mem_rd_en;
      repeat (9) begin
         @(negedge clk);
         rd_w += o_mem_rd_en;
      end
      check("stall_window_reads", {31'h0, rd_w <= 2}, 32'h1);
      @(posedge clk); #1 i_ready = 1'b1;
      hs = 0;
      for (int k = 0; k < TOTAL; k++) begin
         @(negedge clk);
         if (o_weight_valid && i_ready) hs++;
      end
      check("no_gap_handshakes", hs, TOTAL);
      wait_done(20);
      check("stall_words", n_words, TOTAL);

      // Abort while layer 10 address 100 is presented.
      sb_reset();
      pulse_start();
      wait_tag({2'd2, 11'd100}, 1000);
      i_abort = 1'b1;
      @(posedge clk); #1 i_abort = 1'b0;
      @(negedge clk);
      check("abort_flags", {29'h0, o_weight_valid, o_busy, o_load_weight_done}, 32'h0);
      sb_reset();
      pulse_start();
      wait_done(1000);
      check("abort_replay_words", n_words, TOTAL);

      // Start pulses during LOAD are ignored.
      sb_reset();
      pulse_start();
      repeat (50) @(negedge clk);
      pulse_start();
      repeat (300) @(negedge clk);
      pulse_start();
      wait_done(1000);
      check("ignored_start_words", n_words, TOTAL);

      // Start in DONE clears done and reloads; abort in DONE clears done.
      sb_reset();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      @(negedge clk);
      check("done_restart", {30'h0, o_busy, o_load_weight_done}, 32'h2);
      wait_done(1000);
      check("restart_words", n_words, TOTAL);
      @(posedge clk); #1 i_abort = 1'b1;
      @(posedge clk); #1 i_abort = 1'b0;
      @(negedge clk);
      check("abort_in_done", {30'h0, o_busy, o_load_weight_done}, 32'h0);

      // Asynchronous reset mid layer 11.
      sb_reset();
      pulse_start();
      wait_tag({2'd3, 11'd10}, 1000);
      mon_on = 1'b0;
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(posedge clk); #1 rst = 1'b0;
      sb_reset(); mon_on = 1'b1;
      pulse_start();
      wait_done(1000);
      check("post_reset_words", n_words, TOTAL);

      mon_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
